// File: rtl/gyro_pkg.sv
// Shared types and width helpers for the gyro angle integrator.
package gyro_pkg;

  typedef enum logic {RUN = 1'b0, CAL = 1'b1} state_e;
  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

  localparam int DIFF_GROW = 1;  // bias subtract can carry one extra bit
  localparam int PROD_GROW = 2;  // sign bit of diff plus zero-extended scale

  function automatic int diff_w(input int data_w);
    return data_w + DIFF_GROW;
  endfunction

  function automatic int prod_w(input int data_w, input int scale_w);
    return data_w + scale_w + PROD_GROW;
  endfunction

  function automatic int sum_w(input int data_w, input int cal_log2);
    return data_w + cal_log2;
  endfunction

  // Signed add overflow: operands share a sign that the result lost.
  function automatic sat_e sat_check(input logic a_s, input logic b_s, input logic r_s);
    if (a_s == b_s && r_s != a_s) return a_s ? SAT_NEG : SAT_POS;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/gyro_axis_path.sv
// One axis: bias subtract, scale/shift, accumulate, and calibration sum.
module gyro_axis_path
  import gyro_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int SCALE_W   = 16,
  parameter int FRAC_BITS = 16,
  parameter int CAL_LOG2  = 6,
  parameter int WRAP_MODE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  gyro,
  input  logic [SCALE_W-1:0] scale,
  input  logic               s1_en,
  input  logic               s2_en,
  input  logic               s3_en,
  input  logic               zero,
  input  logic               cal_clr,
  input  logic               cal_add,
  input  logic               cal_load,
  output logic [ACC_W-1:0]   angle,
  output logic [DATA_W-1:0]  bias
);
  localparam int DIFF_W = diff_w(DATA_W);
  localparam int PROD_W = prod_w(DATA_W, SCALE_W);
  localparam int SUM_W  = sum_w(DATA_W, CAL_LOG2);

  logic signed [DIFF_W-1:0] diff_q, diff_d;
  logic signed [PROD_W-1:0] prod, prod_sh;
  logic signed [ACC_W-1:0]  delta_q, delta_d, angle_q, angle_d, angle_sum, angle_sat;
  logic signed [SUM_W-1:0]  sum_q, sum_d, sum_sh, g_ext;
  logic [DATA_W-1:0]        bias_q, bias_d;

  assign prod    = PROD_W'(diff_q) * PROD_W'($signed({1'b0, scale}));
  assign prod_sh = prod >>> FRAC_BITS;
  assign g_ext   = SUM_W'($signed(gyro));

  always_comb begin
    diff_d  = s1_en ? DIFF_W'($signed(gyro)) - DIFF_W'($signed(bias_q)) : diff_q;
    delta_d = s2_en ? ACC_W'(prod_sh) : delta_q;

    angle_sum = angle_q + delta_q;
    angle_sat = angle_sum;
    case (sat_check(angle_q[ACC_W-1], delta_q[ACC_W-1], angle_sum[ACC_W-1]))
      SAT_POS: angle_sat = {1'b0, {(ACC_W-1){1'b1}}};
      SAT_NEG: angle_sat = {1'b1, {(ACC_W-1){1'b0}}};
      default: angle_sat = angle_sum;
    endcase

    angle_d = angle_q;
    if (s3_en) angle_d = (WRAP_MODE != 0) ? angle_sum : angle_sat;
    if (zero)  angle_d = '0;

    // The final calibration sample is folded in before the average is taken.
    sum_d  = (cal_clr ? '0 : sum_q) + (cal_add ? g_ext : '0);
    sum_sh = sum_d >>> CAL_LOG2;
    bias_d = cal_load ? DATA_W'(sum_sh) : bias_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q  <= '0;
      delta_q <= '0;
      angle_q <= '0;
      sum_q   <= '0;
      bias_q  <= '0;
    end else begin
      diff_q  <= diff_d;
      delta_q <= delta_d;
      angle_q <= angle_d;
      sum_q   <= sum_d;
      bias_q  <= bias_d;
    end
  end

  assign angle = angle_q;
  assign bias  = bias_q;

endmodule

// File: rtl/gyro_integrator.sv
// Multi-axis gyro angle integrator: RUN/CAL control, valid pipeline, per-axis paths.
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int NUM_AXES  = 3,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int SCALE_W   = 16,
  parameter int FRAC_BITS = 16,
  parameter int CAL_LOG2  = 6,
  parameter int WRAP_MODE = 1
) (
  input  logic                         clk_100mhz,
  input  logic                         rst_n_in,
  input  logic [NUM_AXES*DATA_W-1:0]   gyro_in,
  input  logic                         gyro_valid_in,
  input  logic [SCALE_W-1:0]           scale_in,
  input  logic                         cal_start_in,
  input  logic                         zero_in,
  output logic [NUM_AXES*ACC_W-1:0]    angle_out,
  output logic                         angle_valid_out,
  output logic                         cal_busy_out,
  output logic                         cal_done_out,
  output logic [NUM_AXES*DATA_W-1:0]   bias_out
);
  localparam int STAGES = 3;
  localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

  state_e                          state_q;
  logic [CAL_LOG2-1:0]             cnt_q;
  logic                            cal_busy_q, cal_done_q;
  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:1]                 vld_pipe_q, vld_pipe_d;
  logic [SCALE_W-1:0]              scale_q, scale_d;
  logic                            accept, cal_start, cal_add, cal_load;
  logic [NUM_AXES-1:0][DATA_W-1:0] gyro_a, bias_a;
  logic [NUM_AXES-1:0][ACC_W-1:0]  angle_a;

  assign gyro_a = gyro_in;

  always_comb begin
    cal_start = (state_q == RUN) && cal_start_in;
    // A sample coincident with cal_start_in belongs to calibration.
    accept    = gyro_valid_in && (state_q == RUN) && !cal_start_in;
    cal_add   = gyro_valid_in && ((state_q == CAL) || cal_start);
    cal_load  = gyro_valid_in && (state_q == CAL) && (cnt_q == CNT_LAST);
    vld_pipe  = {vld_pipe_q, accept};
    vld_pipe_d = zero_in ? '0 : vld_pipe[STAGES-1:0];
    scale_d   = accept ? scale_in : scale_q;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      cal_done_q <= 1'b0;
      case (state_q)
        RUN: if (cal_start_in) begin
          state_q    <= CAL;
          cal_busy_q <= 1'b1;
          cnt_q      <= CAL_LOG2'(gyro_valid_in);
        end
        CAL: if (gyro_valid_in) begin
          cnt_q <= cnt_q + CAL_LOG2'(1);
          if (cnt_q == CNT_LAST) begin
            state_q    <= RUN;
            cal_busy_q <= 1'b0;
            cal_done_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe_q <= '0;
      scale_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      scale_q    <= scale_d;
    end
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    gyro_axis_path #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .SCALE_W(SCALE_W),
      .FRAC_BITS(FRAC_BITS), .CAL_LOG2(CAL_LOG2), .WRAP_MODE(WRAP_MODE)
    ) u_axis (
      .clk(clk_100mhz), .rst_n(rst_n_in),
      .gyro(gyro_a[a]), .scale(scale_q),
      .s1_en(vld_pipe[0]), .s2_en(vld_pipe[1]), .s3_en(vld_pipe[2]),
      .zero(zero_in), .cal_clr(cal_start), .cal_add(cal_add), .cal_load(cal_load),
      .angle(angle_a[a]), .bias(bias_a[a])
    );
  end

  assign angle_out       = angle_a;
  assign bias_out        = bias_a;
  assign angle_valid_out = vld_pipe[STAGES];
  assign cal_busy_out    = cal_busy_q;
  assign cal_done_out    = cal_done_q;

endmodule

// File: tb/tb_gyro_integrator.sv
// Scoreboard bench: wrap and saturate builds driven in lockstep against a behavioural model.
module tb_gyro_integrator;
  localparam int FB  = 16;
  localparam int ONE = 1 << 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] gyro_in = '0;
  logic        gyro_valid = 1'b0;
  logic [16:0] scale = '0;
  logic        cal_start = 1'b0;
  logic        zero = 1'b0;
  logic [47:0] angle_w, angle_s, bias_w, bias_s;
  logic        vw, vs, busy_w, busy_s, done_w, done_s;

  always #5 clk = ~clk;

  gyro_integrator #(.NUM_AXES(3), .DATA_W(16), .ACC_W(16), .SCALE_W(17),
    .FRAC_BITS(16), .CAL_LOG2(2), .WRAP_MODE(1)) u_wrap (
    .clk_100mhz(clk), .rst_n_in(rst_n), .gyro_in(gyro_in), .gyro_valid_in(gyro_valid),
    .scale_in(scale), .cal_start_in(cal_start), .zero_in(zero), .angle_out(angle_w),
    .angle_valid_out(vw), .cal_busy_out(busy_w), .cal_done_out(done_w), .bias_out(bias_w));

  gyro_integrator #(.NUM_AXES(3), .DATA_W(16), .ACC_W(16), .SCALE_W(17),
    .FRAC_BITS(16), .CAL_LOG2(2), .WRAP_MODE(0)) u_sat (
    .clk_100mhz(clk), .rst_n_in(rst_n), .gyro_in(gyro_in), .gyro_valid_in(gyro_valid),
    .scale_in(scale), .cal_start_in(cal_start), .zero_in(zero), .angle_out(angle_s),
    .angle_valid_out(vs), .cal_busy_out(busy_s), .cal_done_out(done_s), .bias_out(bias_s));

  typedef struct { logic [47:0] w; logic [47:0] s; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0, cyc = 0;
  int m_w[3], m_s[3], m_bias[3], m_sum[3];
  bit m_cal = 0;
  int m_cnt = 0;
  int vcount = 0, first_vcyc = -1, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] pack3(input int v0, input int v1, input int v2);
    return {16'(v2), 16'(v1), 16'(v0)};
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin m_w[a] = 0; m_s[a] = 0; end
    sb.delete();
  endtask

  // Drives one sample and predicts its effect in the model.
  task automatic send(input int g0, input int g1, input int g2, input int sc, input bit cs);
    int g[3];
    longint p;
    int d, t;
    g = '{g0, g1, g2};
    @(posedge clk); #1;
    gyro_in = {16'(g2), 16'(g1), 16'(g0)};
    gyro_valid = 1'b1; scale = 17'(sc); cal_start = cs; zero = 1'b0;
    if (m_cal || cs) begin
      if (!m_cal) begin m_cal = 1; m_cnt = 0; m_sum = '{0, 0, 0}; end
      for (int a = 0; a < 3; a++) m_sum[a] += g[a];
      m_cnt++;
      if (m_cnt == 4) begin
        for (int a = 0; a < 3; a++) m_bias[a] = m_sum[a] >>> 2;
        m_cal = 0;
      end
    end else begin
      for (int a = 0; a < 3; a++) begin
        p = longint'(g[a] - m_bias[a]) * longint'(sc);
        d = int'(shortint'(p >>> FB));
        m_w[a] = int'(shortint'(m_w[a] + d));
        t = m_s[a] + d;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        m_s[a] = t;
      end
      sb.push_back('{pack3(m_w[0], m_w[1], m_w[2]), pack3(m_s[0], m_s[1], m_s[2])});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      gyro_valid = 1'b0; cal_start = 1'b0; zero = 1'b0;
    end
  endtask

  task automatic zero_pulse();
    @(posedge clk); #1;
    gyro_valid = 1'b0; cal_start = 1'b0; zero = 1'b1;
    model_clear();
    @(posedge clk); #1;
    zero = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every angle_valid_out pops one expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vw === 1'b1 || vs === 1'b1) begin
        total++;
        if (vw !== vs) begin
          bad++; $display("FAIL valid_pair wrap=%b sat=%b required equal", vw, vs);
        end else if (sb.size() == 0) begin
          bad++; $display("FAIL unexpected_valid angle=%h required no pulse", angle_w);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (angle_w !== e.w || angle_s !== e.s) begin
            bad++;
            $display("FAIL sb_angle wrap=%h sat=%h required wrap=%h sat=%h", angle_w, angle_s, e.w, e.s);
          end
        end
        vcount++;
        if (first_vcyc < 0) first_vcyc = cyc;
      end
      if (done_w === 1'b1) done_cnt++;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (angle_w !== '0 || angle_s !== '0) begin
      bad++; $display("FAIL reset_angle wrap=%h sat=%h required 0", angle_w, angle_s);
    end
    total++;
    if ({vw, vs, busy_w, busy_s, done_w, done_s} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b required 000000", {vw, vs, busy_w, busy_s, done_w, done_s});
    end
    total++;
    if (bias_w !== '0 || bias_s !== '0) begin
      bad++; $display("FAIL reset_bias wrap=%h sat=%h required 0", bias_w, bias_s);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (angle_w !== '0 || vw !== 1'b0 || busy_w !== 1'b0) begin
      bad++; $display("FAIL post_reset angle=%h valid=%b busy=%b required 0", angle_w, vw, busy_w);
    end
  endtask

  task automatic test_integrate();
    int c0 = 0;
    first_vcyc = -1; vcount = 0;
    for (int i = 0; i < 5; i++) begin
      send(100, 0, 0, ONE, 1'b0);
      if (i == 0) c0 = cyc;
    end
    idle(1); drain();
    total++;
    if (vcount != 5) begin bad++; $display("FAIL b2b_count got=%0d required=5", vcount); end
    total++;
    if (first_vcyc - c0 != 3) begin bad++; $display("FAIL latency got=%0d required=3", first_vcyc - c0); end
    total++;
    if (angle_w !== pack3(500, 0, 0) || angle_s !== pack3(500, 0, 0)) begin
      bad++; $display("FAIL integrate_500 wrap=%h sat=%h required %h", angle_w, angle_s, pack3(500, 0, 0));
    end
  endtask

  task automatic test_cal();
    done_cnt = 0;
    send(0, 10, 0, ONE, 1'b1);
    @(negedge clk); total++;
    if (busy_w !== 1'b0) begin bad++; $display("FAIL busy_start got=%b required 0", busy_w); end
    send(0, 11, 0, ONE, 1'b0);
    @(negedge clk); total++;
    if (busy_w !== 1'b1) begin bad++; $display("FAIL busy_mid got=%b required 1", busy_w); end
    @(posedge clk); #1 gyro_valid = 1'b0; cal_start = 1'b1;
    send(0, 12, 0, ONE, 1'b0);
    send(0, 13, 0, ONE, 1'b0);
    @(negedge clk); total++;
    if (busy_w !== 1'b1) begin bad++; $display("FAIL busy_last got=%b required 1", busy_w); end
    idle(1);
    @(negedge clk); total++;
    if (done_w !== 1'b1 || busy_w !== 1'b0) begin
      bad++; $display("FAIL cal_done done=%b busy=%b required done=1 busy=0", done_w, busy_w);
    end
    total++;
    if (bias_w !== pack3(0, 11, 0) || bias_s !== pack3(m_bias[0], m_bias[1], m_bias[2])) begin
      bad++; $display("FAIL cal_bias wrap=%h sat=%h required %h", bias_w, bias_s, pack3(0, 11, 0));
    end
    @(negedge clk); total++;
    if (done_w !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL done_pulse now=%b count=%0d required 0 and 1", done_w, done_cnt);
    end
    send(0, 11, 0, ONE, 1'b0);
    idle(1); drain();
    total++;
    if (angle_w !== pack3(500, 0, 0)) begin
      bad++; $display("FAIL bias_applied angle=%h required %h", angle_w, pack3(500, 0, 0));
    end
  endtask

  task automatic test_zero();
    zero_pulse();
    send(1000, 11, 0, ONE, 1'b0);
    idle(1); drain();
    total++;
    if (angle_w !== pack3(1000, 0, 0)) begin
      bad++; $display("FAIL zero_setup angle=%h required %h", angle_w, pack3(1000, 0, 0));
    end
    vcount = 0;
    send(5, 11, 0, ONE, 1'b0);
    send(7, 11, 0, ONE, 1'b0);
    @(posedge clk); #1 gyro_valid = 1'b0; zero = 1'b1;
    model_clear();
    @(posedge clk); #1 zero = 1'b0;
    @(negedge clk); total++;
    if (angle_w !== '0 || angle_s !== '0) begin
      bad++; $display("FAIL zero_wins wrap=%h sat=%h required 0", angle_w, angle_s);
    end
    total++;
    if (bias_w !== pack3(0, 11, 0)) begin
      bad++; $display("FAIL zero_bias got=%h required %h", bias_w, pack3(0, 11, 0));
    end
    idle(5); total++;
    if (vcount != 0) begin bad++; $display("FAIL squash_valid count=%0d required=0", vcount); end
  endtask

  task automatic test_wrap_sat();
    zero_pulse();
    send(0, 11, 32760, ONE, 1'b0);
    send(0, 11, 10, ONE, 1'b0);
    idle(1); drain();
    total++;
    if (angle_w[47:32] !== 16'h8002) begin
      bad++; $display("FAIL wrap_axis2 got=%h required 8002", angle_w[47:32]);
    end
    total++;
    if (angle_s[47:32] !== 16'h7fff) begin
      bad++; $display("FAIL sat_axis2 got=%h required 7fff", angle_s[47:32]);
    end
  endtask

  task automatic test_negative();
    zero_pulse();
    repeat (4) send(-3, 11, 0, 32'h8000, 1'b0);
    idle(1); drain();
    total++;
    if (angle_w[15:0] !== 16'hfff8 || angle_s[15:0] !== 16'hfff8) begin
      bad++; $display("FAIL negative wrap=%h sat=%h required fff8", angle_w[15:0], angle_s[15:0]);
    end
  endtask

  task automatic test_reset_mid_cal();
    send(50, 11, 0, ONE, 1'b1);
    send(50, 11, 0, ONE, 1'b0);
    @(negedge clk); total++;
    if (busy_w !== 1'b1) begin bad++; $display("FAIL busy_before_rst got=%b required 1", busy_w); end
    @(posedge clk); #2;
    rst_n = 1'b0; gyro_valid = 1'b0; cal_start = 1'b0;
    m_cal = 0; m_bias = '{0, 0, 0};
    model_clear();
    #1; total++;
    if (busy_w !== 1'b0 || busy_s !== 1'b0 || bias_w !== '0 || angle_w !== '0 || done_w !== 1'b0) begin
      bad++; $display("FAIL async_reset busy=%b bias=%h angle=%h done=%b required 0", busy_w, bias_w, angle_w, done_w);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(7, 0, 0, ONE, 1'b0);
    idle(1); drain();
    total++;
    if (angle_w !== pack3(7, 0, 0) || busy_w !== 1'b0) begin
      bad++; $display("FAIL run_after_rst angle=%h busy=%b required %h and 0", angle_w, busy_w, pack3(7, 0, 0));
    end
  endtask

  initial begin
    for (int a = 0; a < 3; a++) begin m_w[a] = 0; m_s[a] = 0; m_bias[a] = 0; m_sum[a] = 0; end
    test_reset();
    test_integrate();
    test_cal();
    test_zero();
    test_wrap_sat();
    test_negative();
    test_reset_mid_cal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gyro_integrator.md
# gyro_integrator

Parametrised multi-axis angle integrator between the IMU sample reader and the attitude/display logic. Per accepted raw gyro sample it subtracts a calibrated per-axis bias, scales by a runtime fixed-point rate factor, and accumulates into per-axis angle registers. Integration advances only on valid samples, not every clock. It supports wrap or saturate accumulation, bias calibration and re-zeroing.

## Interface
Parameters:
- NUM_AXES, 3, number of independent channels (pitch/roll/yaw = 3)
- DATA_W, 16, signed raw rate width per axis
- ACC_W, 32, signed angle accumulator width per axis
- SCALE_W, 16, unsigned scale factor width
- FRAC_BITS, 16, right-shift applied to scaled rate
- CAL_LOG2, 6, calibration averages 2^CAL_LOG2 samples
- WRAP_MODE, 1, 1 = modular accumulation (angle wraps), 0 = signed saturation

Ports:
- clk_100mhz  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- gyro_in  in  NUM_AXES*DATA_W  packed signed rates, axis 0 in LSBs
- gyro_valid_in  in  1  one-cycle sample strobe
- scale_in  in  SCALE_W  rate-to-angle factor, sampled with each accepted sample
- cal_start_in  in  1  pulse: begin bias calibration
- zero_in  in  1  pulse: clear all angles
- angle_out  out  NUM_AXES*ACC_W  packed signed angles
- angle_valid_out  out  1  one-cycle pulse, angle_out updated
- cal_busy_out  out  1  high during calibration
- cal_done_out  out  1  one-cycle pulse at calibration completion
- bias_out  out  NUM_AXES*DATA_W  current per-axis bias

## Operation
- FSM states: RUN (default after reset), CAL.
- RUN: each gyro_valid_in enters a 3-stage pipeline: S1 diff = gyro − bias (DATA_W+1 signed); S2 prod = diff × {0,scale} (DATA_W+SCALE_W+2 signed), delta = prod >>> FRAC_BITS, sign-extended/truncated to ACC_W; S3 angle += delta.
- WRAP_MODE=1: two's-complement modular add. WRAP_MODE=0: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- RUN→CAL on cal_start_in: clear sample counter and per-axis sums (DATA_W+CAL_LOG2 signed); pipeline drains normally; new samples do not enter the integrator.
- CAL: each gyro_valid_in adds gyro_in to sums, counter++. On the 2^CAL_LOG2-th sample: bias = sums >>> CAL_LOG2, cal_done_out pulses next cycle, →RUN. Angles hold during CAL.
- cal_start_in while in CAL: ignored.
- zero_in: all angles ← 0 next cycle, S1–S3 valid bits squashed; wins over a same-cycle S3 update. Bias untouched. Legal in either state.
- Each axis independent; same control for all axes.

## Timing
- Reset values: angle_out 0, angle_valid_out 0, cal_busy_out 0, cal_done_out 0, bias_out 0, state RUN, pipeline valids 0.
- Latency: gyro_valid_in at edge t → angle_out/angle_valid_out at edge t+3.
- Throughput: one sample per cycle, back-to-back valids all integrated.
- cal_busy_out high from cycle after cal_start_in through cycle of final calibration sample.
- Samples arriving the cycle cal_start_in is seen are treated as CAL samples.
- Reset asserted mid-operation: everything returns to reset values immediately; calibration aborted, bias lost.

## Structure
- Package gyro_pkg: state enum (RUN, CAL), localparams for derived widths (DIFF_W, PROD_W, SUM_W), saturation min/max helper function.
- Sub-module gyro_axis_path: one axis of S1–S3 (bias subtract, scale, shift, accumulate/saturate, calibration sum); instantiated NUM_AXES times via generate. Top holds FSM, counter, valid pipeline, zero/cal control.

## Test plan
- Reset, defaults, scale=1<<16: axis 0 = 100 for 5 back-to-back valids → angle 0 = 500, angle_valid_out pulses at t+3..t+7, other axes 0.
- Calibration CAL_LOG2=2: four samples axis 1 = 10, 11, 12, 13 → bias 11, cal_done_out one pulse; then sample 11 → no angle change.
- WRAP_MODE=1, ACC_W=16 build: angle 32760, delta +10 → −32766; WRAP_MODE=0 → 32767.
- Negative rate: gyro −3, scale=0x8000 → delta −2 per sample (arithmetic floor); 4 samples → −8.
- zero_in same cycle as S3 update with angle 1000 → angle 0, no angle_valid_out for squashed samples.
- rst_n_in dropped mid-CAL at sample 2 → cal_busy_out 0 immediately, bias 0, state RUN after release.
